// File: rtl/tank_pkg.sv
// Shared codes and types for the tank game match logic.
//   game_end codes : round result coming from the game-state controller
//   game_reset codes: match result sent back to the controller
//   scorer_state_t : state encoding of match_scorer
package tank_pkg;

  localparam logic [1:0] GE_NONE  = 2'b00;
  localparam logic [1:0] GE_T1    = 2'b01;
  localparam logic [1:0] GE_T2    = 2'b10;
  localparam logic [1:0] GE_START = 2'b11;

  localparam logic [1:0] MR_NONE  = 2'b00;
  localparam logic [1:0] MR_T1    = 2'b01;
  localparam logic [1:0] MR_T2    = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_ROUND      = 2'd1,
    ST_HOLD       = 2'd2,
    ST_MATCH_OVER = 2'd3
  } scorer_state_t;

endpackage

// File: rtl/frame_timer.sv
// Counts tick pulses and raises done on the N-th one.
//   CLK   in  system clock
//   RESET in  asynchronous active-high reset
//   clear in  holds the count at zero (dominates tick)
//   tick  in  one-cycle count enable (e.g. frame pulse)
//   done  out combinational pulse, high with the tick that completes N counts;
//             the counter returns to zero on that same edge
module frame_timer #(
  parameter int N = 90
) (
  input  logic CLK,
  input  logic RESET,
  input  logic clear,
  input  logic tick,
  output logic done
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [CW-1:0] count;

  assign done = tick && !clear && (count == LAST);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      count <= '0;
    end else if (clear || done) begin
      count <= '0;
    end else if (tick) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/match_scorer.sv
// Match scorer: counts round wins per tank, declares the match winner and
// requests a new maze after a frame-counted hold following each round.
//   CLK, RESET      clock, asynchronous active-high reset
//   game_end[1:0]   round code from the game-state controller (edge-detected)
//   frame_tick      one pulse per video frame
//   score1, score2  round wins per tank
//   game_reset[1:0] match result, registered and held until a new match
//   maze_req        one-cycle maze regeneration request
//   hold_active     high while the post-round hold is running
// Optional build macro: WIN_BY_TWO_EN (match must be won by a 2-round lead).
//
// state         | meaning
// --------------+-------------------------------------------
// ST_IDLE       | after reset, waiting for a start edge
// ST_ROUND      | match in play, waiting for a round edge
// ST_HOLD       | round over, counting frames before new maze
// ST_MATCH_OVER | winner latched on game_reset, scores frozen
module match_scorer
  import tank_pkg::*;
#(
  parameter int SCORE_W     = 4,
  parameter int WIN_SCORE   = 5,
  parameter int HOLD_FRAMES = 90
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [1:0]         game_end,
  input  logic               frame_tick,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic [1:0]         game_reset,
  output logic               maze_req,
  output logic               hold_active
);

  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};
  localparam logic [SCORE_W:0]   WIN_X     = (SCORE_W + 1)'(WIN_SCORE);

  scorer_state_t      state;
  logic [1:0]         ge_prev;
  logic               round_edge;
  logic               start_edge;
  logic               t2_round;
  logic [SCORE_W-1:0] w_old;
  logic [SCORE_W-1:0] l_old;
  logic [SCORE_W-1:0] w_new;
  logic               match_won;
  logic               timer_clear;
  logic               timer_tick;
  logic               timer_done;

  // The controller holds its codes for many cycles, so only transitions act.
  assign round_edge = ((game_end == GE_T1) || (game_end == GE_T2)) && (ge_prev == GE_NONE);
  assign start_edge = (game_end == GE_START) && (ge_prev != GE_START);
  assign t2_round   = (game_end == GE_T2);

  assign hold_active = (state == ST_HOLD);

  // Timer only runs in HOLD; entering HOLD always starts it from zero.
  assign timer_clear = (state != ST_HOLD) || start_edge;
  assign timer_tick  = frame_tick && (state == ST_HOLD);

  frame_timer #(
    .N(HOLD_FRAMES)
  ) u_hold_timer (
    .CLK   (CLK),
    .RESET (RESET),
    .clear (timer_clear),
    .tick  (timer_tick),
    .done  (timer_done)
  );

  // Winner/loser view of the scores for the current round edge.
  always_comb begin
    w_old = t2_round ? score2 : score1;
    l_old = t2_round ? score1 : score2;
    w_new = (w_old == SCORE_MAX) ? w_old : w_old + SCORE_W'(1);
`ifdef WIN_BY_TWO_EN
    // Reaching saturation ends the match with the round winner as leader
    // (or tied, in which case the round winner takes it). The loser can never
    // already sit at saturation: its own round to get there would have ended
    // the match.
    match_won = (w_new == SCORE_MAX) ||
                (({1'b0, w_new} >= WIN_X) &&
                 ({1'b0, w_new} >= ({1'b0, l_old} + (SCORE_W + 1)'(2))));
`else
    match_won = ({1'b0, w_new} == WIN_X);
`endif
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= ST_IDLE;
      ge_prev    <= GE_NONE;
      score1     <= '0;
      score2     <= '0;
      game_reset <= MR_NONE;
      maze_req   <= 1'b0;
    end else begin
      ge_prev  <= game_end;
      maze_req <= 1'b0;
      if (start_edge) begin
        score1     <= '0;
        score2     <= '0;
        game_reset <= MR_NONE;
        maze_req   <= 1'b1;
        state      <= ST_ROUND;
      end else begin
        case (state)
          ST_ROUND: begin
            if (round_edge) begin
              if (t2_round) score2 <= w_new;
              else          score1 <= w_new;
              if (match_won) begin
                game_reset <= t2_round ? MR_T2 : MR_T1;
                state      <= ST_MATCH_OVER;
              end else begin
                state <= ST_HOLD;
              end
            end
          end
          ST_HOLD: begin
            if (timer_done) begin
              maze_req <= 1'b1;
              state    <= ST_ROUND;
            end
          end
          ST_IDLE, ST_MATCH_OVER: ;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_match_scorer.sv
module tb_match_scorer;
  import tank_pkg::*;

  typedef struct packed {
    logic [3:0] s1;
    logic [3:0] s2;
    logic [1:0] gr;
    logic       ha;
    logic       mr;
  } obs_t;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [1:0] game_end = 2'b00;
  logic       frame_tick = 1'b0;
  logic [3:0] score1, score2;
  logic [1:0] game_reset;
  logic       maze_req, hold_active;

  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_en = 1'b0;
  obs_t exp_q[$];

  match_scorer #(.SCORE_W(4), .WIN_SCORE(3), .HOLD_FRAMES(2)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .game_end   (game_end),
    .frame_tick (frame_tick),
    .score1     (score1),
    .score2     (score2),
    .game_reset (game_reset),
    .maze_req   (maze_req),
    .hold_active(hold_active)
  );

  always #5 CLK = ~CLK;

  function automatic obs_t cur_obs();
    return {score1, score2, game_reset, hold_active, maze_req};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [3:0] s1, input logic [3:0] s2, input logic [1:0] gr,
                      input logic ha, input logic mr);
    obs_t e;
    e = {s1, s2, gr, ha, mr};
    exp_q.push_back(e);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // One frame pulse; afterwards maze_req must equal exp_mr.
  task automatic tick_frame(input logic exp_mr);
    @(posedge CLK); #1 frame_tick = 1'b1;
    @(posedge CLK); #1 frame_tick = 1'b0;
    check("maze_req_after_tick", 32'(maze_req), 32'(exp_mr));
    cycles(3);
  endtask

  task automatic start_match();
    push(4'd0, 4'd0, MR_NONE, 1'b0, 1'b1);
    push(4'd0, 4'd0, MR_NONE, 1'b0, 1'b0);
    game_end = GE_START;
    cycles(4);
    game_end = GE_NONE;
    cycles(2);
  endtask

  // Play one round; s1/s2/gr are the hand-computed results after the round.
  task automatic play_round(input logic [1:0] code, input logic [3:0] s1,
                            input logic [3:0] s2, input logic [1:0] gr);
    if (gr == MR_NONE) begin
      push(s1, s2, MR_NONE, 1'b1, 1'b0);
      push(s1, s2, MR_NONE, 1'b0, 1'b1);
      push(s1, s2, MR_NONE, 1'b0, 1'b0);
    end else begin
      push(s1, s2, gr, 1'b0, 1'b0);
    end
    game_end = code;
    cycles(4);
    game_end = GE_NONE;
    cycles(2);
    if (gr == MR_NONE) begin
      tick_frame(1'b0);
      check("hold_between_ticks", 32'(hold_active), 32'd1);
      tick_frame(1'b1);
    end else begin
      check("final_no_hold", 32'(hold_active), 32'd0);
    end
  endtask

  // Monitor: every change of the observed outputs is one DUT event.
  initial begin
    obs_t prev, cur, e;
    prev = '0;
    forever begin
      @(negedge CLK);
      cur = cur_obs();
      if (mon_en && cur !== prev) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_event: got s1=%0d s2=%0d gr=%b ha=%b mr=%b expected none",
                   cur.s1, cur.s2, cur.gr, cur.ha, cur.mr);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e) begin
            n_bad++;
            $display("FAIL event: got s1=%0d s2=%0d gr=%b ha=%b mr=%b expected s1=%0d s2=%0d gr=%b ha=%b mr=%b",
                     cur.s1, cur.s2, cur.gr, cur.ha, cur.mr, e.s1, e.s2, e.gr, e.ha, e.mr);
          end
        end
      end
      prev = cur;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    cycles(3);
    check("reset_outputs", 32'(cur_obs()), 32'd0);
    RESET = 1'b0;
    mon_en = 1'b1;
    cycles(2);

    // New match from reset.
    start_match();
    check("start_scores", {score1, score2}, 8'h00);

    // Round 1: game_end held at 01 for 50 cycles, counted once.
    push(4'd1, 4'd0, MR_NONE, 1'b1, 1'b0);
    push(4'd1, 4'd0, MR_NONE, 1'b0, 1'b1);
    push(4'd1, 4'd0, MR_NONE, 1'b0, 1'b0);
    game_end = GE_T1;
    cycles(5);
    tick_frame(1'b0);
    check("hold_active_r1", 32'(hold_active), 32'd1);
    tick_frame(1'b1);
    cycles(35);
    check("score1_once", 32'(score1), 32'd1);
    game_end = GE_NONE;
    cycles(2);

    // Rounds 2 and 3: tank1 takes the match 3-0.
    play_round(GE_T1, 4'd2, 4'd0, MR_NONE);
    play_round(GE_T1, 4'd3, 4'd0, MR_T1);
    game_end = GE_T1;
    cycles(10);
    tick_frame(1'b0);
    tick_frame(1'b0);
    game_end = GE_NONE;
    cycles(3);
    check("frozen_scores", {score1, score2}, 8'h30);
    check("held_game_reset", 32'(game_reset), 32'(MR_T1));

    // Restart from MATCH_OVER.
    start_match();
    check("restart_game_reset", 32'(game_reset), 32'(MR_NONE));

    // Async reset in the middle of a hold, between frame ticks.
    push(4'd0, 4'd1, MR_NONE, 1'b1, 1'b0);
    game_end = GE_T2;
    cycles(4);
    game_end = GE_NONE;
    cycles(2);
    tick_frame(1'b0);
    push(4'd0, 4'd0, MR_NONE, 1'b0, 1'b0);
    @(posedge CLK);
    #3 RESET = 1'b1;
    #1 check("async_reset_outputs", 32'(cur_obs()), 32'd0);
    cycles(3);
    RESET = 1'b0;
    cycles(2);
    tick_frame(1'b0);
    tick_frame(1'b0);
    game_end = GE_T1;
    cycles(4);
    game_end = GE_NONE;
    cycles(2);
    check("idle_ignores_round", 32'(score1), 32'd0);

    // Mixed match, tank2 wins 1-3.
    start_match();
    play_round(GE_T2, 4'd0, 4'd1, MR_NONE);
    play_round(GE_T1, 4'd1, 4'd1, MR_NONE);
    play_round(GE_T2, 4'd1, 4'd2, MR_NONE);
    play_round(GE_T2, 4'd1, 4'd3, MR_T2);

    // Start edge aborting a hold: no stale maze_req afterwards.
    start_match();
    push(4'd1, 4'd0, MR_NONE, 1'b1, 1'b0);
    game_end = GE_T1;
    cycles(4);
    game_end = GE_NONE;
    cycles(2);
    tick_frame(1'b0);
    start_match();
    tick_frame(1'b0);
    tick_frame(1'b0);
    check("abort_scores", {score1, score2}, 8'h00);

`ifdef WIN_BY_TWO_EN
    start_match();
    play_round(GE_T1, 4'd1, 4'd0, MR_NONE);
    play_round(GE_T2, 4'd1, 4'd1, MR_NONE);
    play_round(GE_T1, 4'd2, 4'd1, MR_NONE);
    play_round(GE_T2, 4'd2, 4'd2, MR_NONE);
    play_round(GE_T1, 4'd3, 4'd2, MR_NONE);
    play_round(GE_T1, 4'd4, 4'd2, MR_T1);
`endif

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) cycles(1);
    check("events_outstanding", 32'(exp_q.size()), 32'd0);
    cycles(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
